// File: rtl/sobel_window_gen.sv
// Raster-to-3x3-window generator feeding the Sobel convolution stage.
// Two block-RAM line buffers plus a 3x3 shift window; only interior windows are flagged.
module sobel_window_gen #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int DATA_WD = 8,
  localparam int CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW     = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               sof_i,
  input  logic               pix_valid_i,
  input  logic [DATA_WD-1:0] pix_i,
  output logic [DATA_WD-1:0] i_0,
  output logic [DATA_WD-1:0] i_1,
  output logic [DATA_WD-1:0] i_2,
  output logic [DATA_WD-1:0] i_3,
  output logic [DATA_WD-1:0] i_4,
  output logic [DATA_WD-1:0] i_5,
  output logic [DATA_WD-1:0] i_6,
  output logic [DATA_WD-1:0] i_7,
  output logic [DATA_WD-1:0] i_8,
  output logic               win_valid_o,
  output logic               frame_done_o,
  output logic [CW-1:0]      col_o,
  output logic [RW-1:0]      row_o
);

  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_row;
  logic [CW-1:0]      w_col_cur;
  logic [RW-1:0]      w_row_cur;
  logic [CW-1:0]      w_col_nxt;
  logic [RW-1:0]      w_row_nxt;
  logic               w_interior;
  logic               w_last;

  logic [DATA_WD-1:0] r_lb1 [0:IMG_W-1];
  logic [DATA_WD-1:0] r_lb2 [0:IMG_W-1];
  logic [DATA_WD-1:0] r_lb1_q;
  logic [DATA_WD-1:0] r_lb2_q;
  logic [DATA_WD-1:0] r_pix1;
  logic [CW-1:0]      r_col1;
  logic [DATA_WD-1:0] r_win [0:8];

  logic               r_v1;
  logic               r_ok1;
  logic               r_last1;
  logic               r_v2;
  logic               r_ok2;
  logic               r_last2;

  assign col_o = r_col;
  assign row_o = r_row;

  // Position of the pixel presented this cycle; sof overrides the counters.
  always_comb begin
    w_col_cur = r_col;
    w_row_cur = r_row;
    if (sof_i) begin
      w_col_cur = {CW{1'b0}};
      w_row_cur = {RW{1'b0}};
    end else begin
      w_col_cur = r_col;
      w_row_cur = r_row;
    end
  end

  // Raster advance: column wraps into the next row, last pixel wraps the frame.
  always_comb begin
    w_col_nxt = w_col_cur;
    w_row_nxt = w_row_cur;
    if (pix_valid_i) begin
      if (w_col_cur == LAST_COL) begin
        w_col_nxt = {CW{1'b0}};
        if (w_row_cur == LAST_ROW) begin
          w_row_nxt = {RW{1'b0}};
        end else begin
          w_row_nxt = w_row_cur + RW'(1);
        end
      end else begin
        w_col_nxt = w_col_cur + CW'(1);
        w_row_nxt = w_row_cur;
      end
    end else begin
      w_col_nxt = w_col_cur;
      w_row_nxt = w_row_cur;
    end
  end

  // Interior and last-window classification of the pixel being accepted.
  always_comb begin
    w_interior = (w_row_cur >= RW'(2)) && (w_col_cur >= CW'(2));
    w_last     = (w_row_cur == LAST_ROW) && (w_col_cur == LAST_COL);
  end

  // Line buffers: synchronous read at accept, write-back one cycle later (read-before-write).
  always_ff @(posedge clk_i) begin
    r_lb1_q <= r_lb1[w_col_cur];
    r_lb2_q <= r_lb2[w_col_cur];
    r_pix1  <= pix_i;
    r_col1  <= w_col_cur;
    if (r_v1) begin
      r_lb1[r_col1] <= r_pix1;
      r_lb2[r_col1] <= r_lb1_q;
    end
  end

  // 3x3 window storage: new column {row-2, row-1, row} enters on the right.
  always_ff @(posedge clk_i) begin
    if (r_v1) begin
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= r_lb2_q;
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= r_lb1_q;
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= r_pix1;
    end
  end

  // Counters, pipeline valids and registered output taps.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col        <= {CW{1'b0}};
      r_row        <= {RW{1'b0}};
      r_v1         <= 1'b0;
      r_ok1        <= 1'b0;
      r_last1      <= 1'b0;
      r_v2         <= 1'b0;
      r_ok2        <= 1'b0;
      r_last2      <= 1'b0;
      win_valid_o  <= 1'b0;
      frame_done_o <= 1'b0;
      i_0          <= {DATA_WD{1'b0}};
      i_1          <= {DATA_WD{1'b0}};
      i_2          <= {DATA_WD{1'b0}};
      i_3          <= {DATA_WD{1'b0}};
      i_4          <= {DATA_WD{1'b0}};
      i_5          <= {DATA_WD{1'b0}};
      i_6          <= {DATA_WD{1'b0}};
      i_7          <= {DATA_WD{1'b0}};
      i_8          <= {DATA_WD{1'b0}};
    end else begin
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_v1         <= pix_valid_i;
      r_ok1        <= pix_valid_i & w_interior;
      r_last1      <= pix_valid_i & w_interior & w_last;
      r_v2         <= r_v1;
      r_ok2        <= r_ok1;
      r_last2      <= r_last1;
      win_valid_o  <= r_ok2;
      frame_done_o <= r_last2;
      // Taps follow the window only when it shifted; stalls hold the last window.
      if (r_v2) begin
        i_0 <= r_win[0];
        i_1 <= r_win[1];
        i_2 <= r_win[2];
        i_3 <= r_win[3];
        i_4 <= r_win[4];
        i_5 <= r_win[5];
        i_6 <= r_win[6];
        i_7 <= r_win[7];
        i_8 <= r_win[8];
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Randomised bench for sobel_window_gen on an 8x4 image, checked every cycle
// against a frame-array model of the window rules plus literal anchor values.
module tb_sobel_window_gen;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int NW = (W - 2) * (H - 2);

  typedef struct packed {
    logic            valid;
    logic            done;
    logic            known;
    logic [8:0][7:0] taps;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sof;
  logic       pv;
  logic [7:0] pix;
  logic [7:0] t0, t1, t2, t3, t4, t5, t6, t7, t8;
  logic       wv, fd;
  logic [2:0] col;
  logic [1:0] row;

  always #5 clk = ~clk;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_WD(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sof_i(sof), .pix_valid_i(pv), .pix_i(pix),
    .i_0(t0), .i_1(t1), .i_2(t2), .i_3(t3), .i_4(t4), .i_5(t5), .i_6(t6), .i_7(t7), .i_8(t8),
    .win_valid_o(wv), .frame_done_o(fd), .col_o(col), .row_o(row)
  );

  logic [7:0]      img [0:H-1][0:W-1];
  int              mrow, mcol;
  logic [8:0][7:0] last_taps;
  logic            known;
  exp_t            pipe [0:2];
  int              nchk, nerr, nwin, ndone;
  logic [8:0][7:0] wlog [0:63];

  localparam logic [8:0][7:0] FIRST_WIN =
    {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nchk++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
    end
  endtask

  function automatic logic [7:0] pixval(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'((r * 16) + c);
      1:       return 8'(255 - ((r * 16) + c));
      2:       return 8'd77;
      3:       return (c >= 4) ? 8'd200 : 8'd0;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '0;
    z.known = 1'b1;
    for (int i = 0; i < 3; i++) pipe[i] = z;
    last_taps = '0;
    known = 1'b1;
    mrow = 0;
    mcol = 0;
  endtask

  task automatic check_outputs();
    logic [8:0][7:0] dt;
    dt = {t8, t7, t6, t5, t4, t3, t2, t1, t0};
    chk("win_valid", 64'(wv), 64'(pipe[2].valid));
    chk("frame_done", 64'(fd), 64'(pipe[2].done));
    chk("col", 64'(col), 64'(mcol));
    chk("row", 64'(row), 64'(mrow));
    if (pipe[2].known) begin
      for (int k = 0; k < 9; k++) chk($sformatf("tap%0d", k), 64'(dt[k]), 64'(pipe[2].taps[k]));
    end
    if (wv === 1'b1) begin
      if (nwin < 64) wlog[nwin] = dt;
      nwin++;
    end
    if (fd === 1'b1) ndone++;
  endtask

  // One clock of stimulus: check the outputs, drive inputs, advance the model.
  task automatic step(input logic s, input logic v, input logic [7:0] p);
    exp_t e;
    int r, c;
    @(negedge clk);
    check_outputs();
    sof = s;
    pv  = v;
    pix = p;
    e   = '0;
    if (rst_n) begin
      r = s ? 0 : mrow;
      c = s ? 0 : mcol;
      if (v) begin
        img[r][c] = p;
        if (r >= 2 && c >= 2) begin
          for (int k = 0; k < 9; k++) last_taps[k] = img[r - 2 + k / 3][c - 2 + k % 3];
          known   = 1'b1;
          e.valid = 1'b1;
          e.done  = (r == H - 1) && (c == W - 1);
        end else begin
          known = 1'b0;
        end
        c++;
        if (c == W) begin
          c = 0;
          r = (r == H - 1) ? 0 : r + 1;
        end
      end
      mrow = r;
      mcol = c;
    end
    e.known = known;
    e.taps  = last_taps;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = e;
  endtask

  task automatic feed(input int kind, input int idle, input bit sof_first, input int start, input int npix);
    for (int i = start; i < start + npix; i++) begin
      for (int g = 0; g < 20 && $urandom_range(99) < idle; g++) step(1'b0, 1'b0, 8'($urandom));
      step(sof_first && (i == start), 1'b1, pixval(kind, (i / W) % H, i % W));
    end
  endtask

  task automatic drain();
    repeat (4) step(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic check_windows(input int kind, input int base, input int n);
    int j, r, c;
    for (int w = 0; w < n; w++) begin
      j = w % NW;
      r = 2 + j / (W - 2);
      c = 2 + j % (W - 2);
      for (int k = 0; k < 9; k++)
        chk($sformatf("win%0d_tap%0d", base + w, k), 64'(wlog[base + w][k]),
            64'(pixval(kind, r - 2 + k / 3, c - 2 + k % 3)));
    end
  endtask

  task automatic start_phase();
    nwin  = 0;
    ndone = 0;
  endtask

  initial begin
    int gx, gy, cc;
    rst_n = 1'b0;
    sof = 1'b0; pv = 1'b0; pix = 8'd0;
    nchk = 0; nerr = 0;
    start_phase();
    model_reset();
    repeat (3) step(1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;

    // Gapless ramp frame with literal anchors.
    start_phase();
    feed(0, 0, 1'b1, 0, W * H);
    drain();
    chk("t1_windows", 64'(nwin), 64'(12));
    chk("t1_done", 64'(ndone), 64'(1));
    chk("t1_first", 64'(wlog[0]), 64'(FIRST_WIN));
    chk("t1_last_i0", 64'(wlog[11][0]), 64'(8'h15));
    chk("t1_last_i8", 64'(wlog[11][8]), 64'(8'h37));
    check_windows(0, 0, 12);

    // Same frame with ~40% idle cycles.
    start_phase();
    feed(0, 40, 1'b1, 0, W * H);
    drain();
    chk("t2_windows", 64'(nwin), 64'(12));
    check_windows(0, 0, 12);

    // Two back-to-back frames, second inverted.
    start_phase();
    feed(0, 0, 1'b1, 0, W * H);
    feed(1, 0, 1'b0, 0, W * H);
    drain();
    chk("t3_windows", 64'(nwin), 64'(24));
    chk("t3_done", 64'(ndone), 64'(2));
    check_windows(0, 0, 12);
    check_windows(1, 12, 12);

    // sof with a valid pixel at (1,5) restarts the frame.
    start_phase();
    feed(0, 0, 1'b1, 0, 13);
    step(1'b1, 1'b1, pixval(0, 0, 0));
    step(1'b0, 1'b0, 8'd0);
    chk("t4_sof_col", 64'(col), 64'(1));
    chk("t4_sof_row", 64'(row), 64'(0));
    feed(0, 10, 1'b0, 1, W * H - 1);
    drain();
    chk("t4_windows", 64'(nwin), 64'(12));
    chk("t4_done", 64'(ndone), 64'(1));
    check_windows(0, 0, 12);

    // Asynchronous reset in the middle of row 2.
    start_phase();
    feed(0, 0, 1'b1, 0, 18);
    step(1'b0, 1'b1, pixval(0, 2, 2));
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", 64'(wv), 64'(0));
    chk("t5_async_done", 64'(fd), 64'(0));
    chk("t5_async_col", 64'(col), 64'(0));
    chk("t5_async_row", 64'(row), 64'(0));
    chk("t5_async_taps", 64'({t8, t7, t6, t5, t4, t3, t2, t1, t0}), 64'(0));
    model_reset();
    step(1'b0, 1'b0, 8'd0);
    rst_n = 1'b1;
    start_phase();
    feed(0, 20, 1'b0, 0, W * H);
    drain();
    chk("t5_windows", 64'(nwin), 64'(12));
    chk("t5_done", 64'(ndone), 64'(1));
    check_windows(0, 0, 12);

    // Sobel response: flat image gives zero, vertical step 0->200 at col 4.
    start_phase();
    feed(2, 0, 1'b1, 0, W * H);
    drain();
    chk("t6_flat_windows", 64'(nwin), 64'(12));
    for (int w = 0; w < 12 && w < nwin; w++) begin
      gx = (int'(wlog[w][2]) + 2 * int'(wlog[w][5]) + int'(wlog[w][8]))
         - (int'(wlog[w][0]) + 2 * int'(wlog[w][3]) + int'(wlog[w][6]));
      gy = (int'(wlog[w][6]) + 2 * int'(wlog[w][7]) + int'(wlog[w][8]))
         - (int'(wlog[w][0]) + 2 * int'(wlog[w][1]) + int'(wlog[w][2]));
      chk("t6_flat_gx", 64'(gx), 64'(0));
      chk("t6_flat_gy", 64'(gy), 64'(0));
    end
    start_phase();
    feed(3, 30, 1'b1, 0, W * H);
    drain();
    chk("t6_step_windows", 64'(nwin), 64'(12));
    for (int w = 0; w < 12 && w < nwin; w++) begin
      cc = 1 + w % (W - 2);
      gx = (int'(wlog[w][2]) + 2 * int'(wlog[w][5]) + int'(wlog[w][8]))
         - (int'(wlog[w][0]) + 2 * int'(wlog[w][3]) + int'(wlog[w][6]));
      chk($sformatf("t6_step_gx_c%0d", cc), 64'(gx), (cc == 3 || cc == 4) ? 64'(800) : 64'(0));
    end

    // Random pixels with random gaps over three frames.
    start_phase();
    feed(4, 40, 1'b1, 0, 3 * W * H);
    drain();
    chk("t7_windows", 64'(nwin), 64'(36));
    chk("t7_done", 64'(ndone), 64'(3));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Raster-to-window producer that sits in front of the Sobel convolution stage.
- Accepts one 8-bit grey pixel per valid cycle in row-major order. Keeps the two previous image lines in line buffers.
- Emits the 3x3 neighbourhood (taps i_0..i_8) plus a window-valid strobe that drives the convolution's enable input.
- Emits only interior windows, plus an end-of-frame pulse.

Parameters:
- IMG_W, 640, pixels per line (>= 3)
- IMG_H, 480, lines per frame (>= 3)
- DATA_WD, 8, pixel width in bits

Ports:
- clk_i  in  1  system clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- sof_i  in  1  start-of-frame, synchronous clear of position counters
- pix_valid_i  in  1  pix_i valid this cycle (no backpressure, always accepted)
- pix_i  in  DATA_WD  incoming pixel
- i_0 .. i_8  out  DATA_WD each  window taps, registered
- win_valid_o  out  1  taps hold a valid interior window this cycle
- frame_done_o  out  1  one-cycle pulse on the last window of a frame
- col_o  out  $clog2(IMG_W)  column of the next pixel to be accepted
- row_o  out  $clog2(IMG_H)  row of the next pixel to be accepted

Behaviour:
- Reset: all outputs 0, counters 0, pipeline valids 0. Line-buffer and window storage contents are not reset; row/col gating hides stale data. Reset mid-frame aborts the frame; the next accepted pixel is (0,0).
- Position counters advance on each accepted pixel:
  - col wraps IMG_W-1 -> 0, and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0; frames run back-to-back with no gap.
- sof_i forces the counters to 0 that cycle. If pix_valid_i is also high, that pixel is (0,0) and the counters become (0,1).
- Line buffers: two IMG_W-deep arrays, LB1 = row r-1 and LB2 = row r-2. They must map to synchronous-read block RAM.
  - Accepting pixel (r,c) reads LB1[c] and LB2[c].
  - One cycle later it writes LB2[c] <= old LB1[c] and LB1[c] <= pix_i.
- Pipeline:
  - Stage 0: accept and read.
  - Stage 1: the column {LB2[c], LB1[c], pix} shifts into the 3x3 register.
  - Stage 2: the taps are registered onto the outputs.
- Latency: exactly 2 cycles from acceptance of pixel (r,c) to the window whose right column is c.
- Tap map for accepted pixel (r,c):
  - i_0 = (r-2,c-2), i_1 = (r-2,c-1), i_2 = (r-2,c)
  - i_3 = (r-1,c-2), i_4 = (r-1,c-1), i_5 = (r-1,c)
  - i_6 = (r,c-2), i_7 = (r,c-1), i_8 = (r,c)
  - Window centre is (r-1,c-1).
- win_valid_o = 1 exactly 2 cycles after accepting a pixel with r >= 2 and c >= 2; otherwise 0.
  - Per frame: (IMG_W-2)*(IMG_H-2) windows, e.g. 638*478 = 304964.
  - Windows spanning a line wrap (c < 2) are never flagged.
- Stalls (pix_valid_i = 0): nothing shifts, no buffer write, taps hold their last value. win_valid_o is 0 for the corresponding cycle two cycles later. Arbitrary gap patterns must give the same window sequence as gapless input.
- frame_done_o = 1 coincident with win_valid_o for the window from pixel (IMG_H-1, IMG_W-1).
- sof_i mid-frame: abandons the partial frame, with no frame_done_o. Windows already in the 2-stage pipeline still emerge.

Test Plan:
- IMG_W=8, IMG_H=4, gapless, pix = row*16+col -> exactly 12 win_valid_o pulses.
  - First pulse comes 2 cycles after pixel (2,2): i_0..i_8 = 00,01,02,10,11,12,20,21,22.
  - Last pulse: i_0 = 15, i_8 = 37, with frame_done_o = 1.
- Same image with random pix_valid_i gaps (~40% idle) -> identical 12 tap sets in the same order; taps hold during gaps.
- Two back-to-back frames (second frame pixel = 0xFF - first value) -> 24 windows total. Windows 1-12 use only frame-1 data and windows 13-24 only frame-2 data. No window is flagged on rows 0-1 of frame 2.
- sof_i with pix_valid_i at pixel (1,5) of frame 1 -> counters become (0,1), no frame_done_o, then a full correct 12-window frame.
- rst_ni low for 1 cycle mid-row 2 -> all outputs 0 asynchronously; after release a fresh frame yields 12 correct windows.
- Default parameters, full 640x480 ramp frame -> 304964 windows.
  - Downstream Sobel output is 0 everywhere for a constant image.
  - Vertical step at col 320 (0 to 200) -> sum = 800 only for centres at columns 319-320.
